matrix_readout_ctrl: RTL and testbench

Sequences the column-drain readout of one front-end flavour of the pixel matrix (COMP, HV, PMOS or PMOS_DPW; one instance per flavour). It watches the per-double-column active-low token lines, freezes the flavour, and reads out every tokened column in ascending index order. Each hit's 21-bit data slice is captured and delivered as a word with column address and freeze timestamp on a valid/ready stream. It sits between the matrix macro and the digital serializer/FIFO.

---
 rtl/matrix_ro_pkg.sv | 29 ++
 rtl/matrix_readout_ctrl_if.sv | 38 +++
 rtl/tok_prio_enc.sv | 26 ++
 rtl/matrix_readout_ctrl.sv | 173 +++++++++++++++++
 tb/tb_matrix_readout_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_ro_pkg.sv
// rtl/matrix_ro_pkg.sv - shared types and default sizes for the matrix column-drain readout
// Holds the controller state encoding, default geometry/timing values and a
// small sizing helper used to dimension the shared down-counter.
package matrix_ro_pkg;

    localparam int DEF_N_COL    = 56;
    localparam int DEF_DATA_W   = 21;
    localparam int DEF_TS_W     = 16;
    localparam int DEF_FRZ_DLY  = 2;
    localparam int DEF_RD_LEN   = 2;
    localparam int DEF_DATA_DLY = 3;
    localparam int COL_W        = $clog2(DEF_N_COL);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SCAN,
        READ,
        WAIT,
        OUT
    } ro_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/matrix_readout_ctrl_if.sv
// rtl/matrix_readout_ctrl_if.sv - hit-word output stream between readout controller and serializer/FIFO
// Signals:
//   out_valid  hit word valid (driven by master)
//   out_ready  downstream accepts (driven by slave)
//   out_col    column index of the hit
//   out_data   captured column data
//   out_ts     timestamp latched when the frame froze
interface matrix_readout_ctrl_if
    import matrix_ro_pkg::*;
#(
    parameter int COL_BITS = COL_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TS_W     = DEF_TS_W
);

    logic                out_valid;
    logic                out_ready;
    logic [COL_BITS-1:0] out_col;
    logic [DATA_W-1:0]   out_data;
    logic [TS_W-1:0]     out_ts;

    modport master (
        output out_valid,
        output out_col,
        output out_data,
        output out_ts,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_col,
        input  out_data,
        input  out_ts,
        output out_ready
    );

endinterface

// File: rtl/tok_prio_enc.sv
// rtl/tok_prio_enc.sv - N-input lowest-index-wins priority encoder for column tokens
// Ports:
//   req_i    request vector (1 = column requests readout)
//   found_o  at least one request present
//   idx_o    index of the lowest set request bit (0 when none)
module tok_prio_enc #(
    parameter int N     = 56,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/matrix_readout_ctrl.sv
// rtl/matrix_readout_ctrl.sv - column-drain readout sequencer for one pixel-matrix front-end flavour
// Ports:
//   CLK, nRST  readout clock, asynchronous active-low reset
//   EN         readout enable, only looked at while idle
//   nTOK       per-column token, low = hit pending
//   Data       packed column data, column c at Data[c*DATA_W +: DATA_W]
//   FREEZE     freeze to matrix, all bits identical
//   Read       one-hot column read strobe
//   busy       high whenever a frame is in progress
//   out_if     hit-word stream (column, data, freeze timestamp)
module matrix_readout_ctrl
    import matrix_ro_pkg::*;
#(
    parameter int N_COL    = DEF_N_COL,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TS_W     = DEF_TS_W,
    parameter int FRZ_DLY  = DEF_FRZ_DLY,
    parameter int RD_LEN   = DEF_RD_LEN,
    parameter int DATA_DLY = DEF_DATA_DLY
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      EN,
    input  logic [N_COL-1:0]          nTOK,
    input  logic [N_COL*DATA_W-1:0]   Data,
    output logic [N_COL-1:0]          FREEZE,
    output logic [N_COL-1:0]          Read,
    output logic                      busy,
    matrix_readout_ctrl_if.master     out_if
);

    localparam int CW    = $clog2(N_COL);
    // One counter serves settle, read-pulse and data-delay phases.
    localparam int CNT_W = $clog2(max3(FRZ_DLY, RD_LEN, DATA_DLY) + 1);

    ro_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]      col_q, col_d;
    logic [TS_W-1:0]    ts_q;
    logic [TS_W-1:0]    ts_frz_q, ts_frz_d;
    logic               out_valid_q, out_valid_d;
    logic [CW-1:0]      out_col_q, out_col_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [TS_W-1:0]    out_ts_q, out_ts_d;

    logic               tok_found;
    logic [CW-1:0]      tok_idx;
    logic [DATA_W-1:0]  data_col [N_COL];

    for (genvar c = 0; c < N_COL; c++) begin : g_data_col
        assign data_col[c] = Data[c*DATA_W +: DATA_W];
    end

    tok_prio_enc #(
        .N     (N_COL),
        .IDX_W (CW)
    ) u_tok_prio_enc (
        .req_i   (~nTOK),
        .found_o (tok_found),
        .idx_o   (tok_idx)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            col_q       <= '0;
            ts_q        <= '0;
            ts_frz_q    <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_data_q  <= '0;
            out_ts_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            ts_q        <= ts_q + 1'b1;
            ts_frz_q    <= ts_frz_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            out_data_q  <= out_data_d;
            out_ts_q    <= out_ts_d;
        end
    end

    // Counted phases leave on the edge where cnt would reach zero, so a load
    // of N gives exactly N cycles in that phase.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        ts_frz_d    = ts_frz_q;
        out_valid_d = out_valid_q;
        out_col_d   = out_col_q;
        out_data_d  = out_data_q;
        out_ts_d    = out_ts_q;

        case (state_q)
            IDLE: begin
                if (EN && !(&nTOK)) begin
                    ts_frz_d = ts_q;
                    cnt_d    = CNT_W'(FRZ_DLY);
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SCAN: begin
                if (tok_found) begin
                    col_d   = tok_idx;
                    cnt_d   = CNT_W'(RD_LEN);
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = CNT_W'(DATA_DLY);
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_col_d   = col_q;
                    out_data_d  = data_col[col_q];
                    out_ts_d    = ts_frz_q;
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            OUT: begin
                if (out_if.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = SCAN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so reset clears them
    // without waiting for a clock edge.
    always_comb begin
        Read = '0;
        if (state_q == READ) begin
            Read[col_q] = 1'b1;
        end
    end

    assign busy   = (state_q != IDLE);
    assign FREEZE = {N_COL{busy}};

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_col   = out_col_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_ts    = out_ts_q;

endmodule

// File: tb/tb_matrix_readout_ctrl.sv
// tb/tb_matrix_readout_ctrl.sv - directed self-checking bench for matrix_readout_ctrl
module tb_matrix_readout_ctrl;

    localparam int NC = 56;
    localparam int DW = 21;
    localparam int TW = 16;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic            EN = 1'b0;
    logic [NC-1:0]   nTOK;
    logic [NC*DW-1:0] Data;
    logic [NC-1:0]   FREEZE;
    logic [NC-1:0]   Read;
    logic            busy;

    matrix_readout_ctrl_if out_if ();

    matrix_readout_ctrl dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .EN     (EN),
        .nTOK   (nTOK),
        .Data   (Data),
        .FREEZE (FREEZE),
        .Read   (Read),
        .busy   (busy),
        .out_if (out_if)
    );

    int checks = 0;
    int errors = 0;
    logic [TW-1:0] tb_ts;
    logic [TW-1:0] exp_ts;
    logic [NC-1:0] all_ones;

    always #5 CLK = ~CLK;

    // Reference free-running timestamp: value before each rising edge.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) tb_ts <= '0;
        else       tb_ts <= tb_ts + 1'b1;
    end

    task automatic set_data(input int c, input logic [DW-1:0] v);
        Data[c*DW +: DW] = v;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (out_if.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge CLK);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; EN = 1'b0; nTOK = '1; Data = '1; out_if.out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (FREEZE !== '0) begin errors++; $display("FAIL reset_freeze got=%h exp=0", FREEZE); end
        checks++; if (Read !== '0) begin errors++; $display("FAIL reset_read got=%h exp=0", Read); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_if.out_valid); end
        checks++; if (out_if.out_col !== 6'd0 || out_if.out_data !== 21'd0 || out_if.out_ts !== 16'd0) begin
            errors++; $display("FAIL reset_outs col=%h data=%h ts=%h exp=0", out_if.out_col, out_if.out_data, out_if.out_ts);
        end
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_tok busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        logic [NC-1:0] rd5;
        rd5 = '0; rd5[5] = 1'b1;
        EN = 1'b1; out_if.out_ready = 1'b1; set_data(5, 21'h1ABCD);
        @(negedge CLK);
        nTOK[5] = 1'b0; exp_ts = tb_ts;
        for (int i = 0; i <= 10; i++) begin
            @(negedge CLK);
            case (i)
                0: begin
                    checks++; if (FREEZE !== all_ones || busy !== 1'b1) begin errors++; $display("FAIL single_freeze freeze=%h busy=%b exp all ones/1", FREEZE, busy); end
                end
                2: begin
                    checks++; if (Read !== '0) begin errors++; $display("FAIL single_read_early got=%h exp=0", Read); end
                end
                3, 4: begin
                    checks++; if (Read !== rd5) begin errors++; $display("FAIL single_read_pulse cyc=%0d got=%h exp=%h", i, Read, rd5); end
                end
                5: begin
                    checks++; if (Read !== '0) begin errors++; $display("FAIL single_read_end got=%h exp=0", Read); end
                    nTOK[5] = 1'b1;
                end
                7: begin
                    checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got=%b exp=0", out_if.out_valid); end
                end
                8: begin
                    checks++; if (out_if.out_valid !== 1'b1 || out_if.out_col !== 6'd5 || out_if.out_data !== 21'h1ABCD || out_if.out_ts !== exp_ts) begin
                        errors++; $display("FAIL single_word v=%b col=%0d data=%h ts=%h exp 1/5/1abcd/%h", out_if.out_valid, out_if.out_col, out_if.out_data, out_if.out_ts, exp_ts);
                    end
                end
                9: begin
                    checks++; if (out_if.out_valid !== 1'b0 || FREEZE !== all_ones) begin errors++; $display("FAIL single_scan v=%b freeze=%h exp 0/all ones", out_if.out_valid, FREEZE); end
                end
                10: begin
                    checks++; if (FREEZE !== '0 || busy !== 1'b0) begin errors++; $display("FAIL single_frame_end freeze=%h busy=%b exp 0/0", FREEZE, busy); end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_multi();
        int nwords;
        int at [3];
        logic [5:0]    cols [3];
        logic [DW-1:0] dats [3];
        bit ok;
        out_if.out_ready = 1'b1;
        set_data(3, 21'h03333); set_data(10, 21'h0AAAA); set_data(55, 21'h15555);
        @(negedge CLK);
        nTOK[3] = 1'b0; nTOK[10] = 1'b0; nTOK[55] = 1'b0;
        nwords = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (out_if.out_valid === 1'b1) begin
                if (nwords < 3) begin
                    cols[nwords] = out_if.out_col; dats[nwords] = out_if.out_data; at[nwords] = i;
                end
                nwords++;
                nTOK[out_if.out_col] = 1'b1;
            end
        end
        checks++; if (nwords != 3) begin errors++; $display("FAIL multi_count got=%0d exp=3", nwords); end
        if (nwords >= 3) begin
            checks++; if (cols[0] !== 6'd3 || cols[1] !== 6'd10 || cols[2] !== 6'd55) begin
                errors++; $display("FAIL multi_order got=%0d,%0d,%0d exp=3,10,55", cols[0], cols[1], cols[2]);
            end
            checks++; if (dats[0] !== 21'h03333 || dats[1] !== 21'h0AAAA || dats[2] !== 21'h15555) begin
                errors++; $display("FAIL multi_data got=%h,%h,%h exp=03333,0aaaa,15555", dats[0], dats[1], dats[2]);
            end
            checks++; if (at[1] - at[0] != 7 || at[2] - at[1] != 7) begin
                errors++; $display("FAIL multi_spacing got=%0d,%0d exp=7,7", at[1] - at[0], at[2] - at[1]);
            end
        end
        wait_idle(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL multi_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_if.out_ready = 1'b0; set_data(5, 21'h1ABCD);
        @(negedge CLK);
        nTOK[5] = 1'b0; exp_ts = tb_ts;
        wait_valid(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_valid_timeout got=0 exp=1"); end
        nTOK[5] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_if.out_valid !== 1'b1 || out_if.out_col !== 6'd5 || out_if.out_data !== 21'h1ABCD || out_if.out_ts !== exp_ts || Read !== '0) begin
                errors++; $display("FAIL bp_hold cyc=%0d v=%b col=%0d data=%h ts=%h read=%h exp 1/5/1abcd/%h/0",
                                   i, out_if.out_valid, out_if.out_col, out_if.out_data, out_if.out_ts, Read, exp_ts);
            end
            @(negedge CLK);
        end
        out_if.out_ready = 1'b1;
        @(negedge CLK);
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer got=%b exp=0", out_if.out_valid); end
        wait_idle(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_multi_hit();
        int nwords;
        logic [5:0]    cols [3];
        logic [DW-1:0] dats [3];
        logic [TW-1:0] tss  [3];
        bit ok;
        out_if.out_ready = 1'b1; set_data(7, 21'h00111);
        @(negedge CLK);
        nTOK[7] = 1'b0; exp_ts = tb_ts;
        nwords = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (out_if.out_valid === 1'b1) begin
                if (nwords < 3) begin
                    cols[nwords] = out_if.out_col; dats[nwords] = out_if.out_data; tss[nwords] = out_if.out_ts;
                end
                nwords++;
                if (nwords == 1) set_data(7, 21'h00222);
                if (nwords == 2) set_data(7, 21'h00333);
                if (nwords == 3) nTOK[7] = 1'b1;
            end
        end
        checks++; if (nwords != 3) begin errors++; $display("FAIL mhit_count got=%0d exp=3", nwords); end
        if (nwords >= 3) begin
            checks++; if (cols[0] !== 6'd7 || cols[1] !== 6'd7 || cols[2] !== 6'd7) begin
                errors++; $display("FAIL mhit_col got=%0d,%0d,%0d exp=7,7,7", cols[0], cols[1], cols[2]);
            end
            checks++; if (dats[0] !== 21'h00111 || dats[1] !== 21'h00222 || dats[2] !== 21'h00333) begin
                errors++; $display("FAIL mhit_data got=%h,%h,%h exp=00111,00222,00333", dats[0], dats[1], dats[2]);
            end
            checks++; if (tss[0] !== exp_ts || tss[1] !== exp_ts || tss[2] !== exp_ts) begin
                errors++; $display("FAIL mhit_ts got=%h,%h,%h exp=%h", tss[0], tss[1], tss[2], exp_ts);
            end
        end
        wait_idle(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mhit_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_en_reset();
        bit ok;
        EN = 1'b0; nTOK[2] = 1'b0;
        repeat (10) @(negedge CLK);
        checks++; if (FREEZE !== '0 || busy !== 1'b0) begin errors++; $display("FAIL en_off freeze=%h busy=%b exp 0/0", FREEZE, busy); end
        EN = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (Read !== '0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL en_read_timeout got=0 exp=1"); end
        #2 nRST = 1'b0;
        #1;
        checks++; if (Read !== '0 || FREEZE !== '0 || busy !== 1'b0 || out_if.out_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset read=%h freeze=%h busy=%b v=%b exp all 0", Read, FREEZE, busy, out_if.out_valid);
        end
        nTOK = '1;
        @(negedge CLK);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (busy !== 1'b0 || Read !== '0) begin errors++; $display("FAIL reset_restart busy=%b read=%h exp 0/0", busy, Read); end
        set_data(4, 21'h0C0DE); out_if.out_ready = 1'b1;
        nTOK[4] = 1'b0;
        wait_valid(20, ok);
        checks++; if (!ok || out_if.out_col !== 6'd4 || out_if.out_data !== 21'h0C0DE) begin
            errors++; $display("FAIL restart_word ok=%b col=%0d data=%h exp 1/4/0c0de", ok, out_if.out_col, out_if.out_data);
        end
        nTOK[4] = 1'b1;
        wait_idle(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL restart_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_ts_wrap();
        bit ok;
        int n;
        out_if.out_ready = 1'b1; set_data(1, 21'h00F0F);
        n = 0;
        while (tb_ts !== 16'hFFFF && n < 70000) begin
            @(negedge CLK);
            n++;
        end
        nTOK[1] = 1'b0; exp_ts = tb_ts;
        wait_valid(20, ok);
        checks++; if (!ok || out_if.out_ts !== 16'hFFFF || out_if.out_col !== 6'd1) begin
            errors++; $display("FAIL wrap_ffff ok=%b ts=%h col=%0d exp 1/ffff/1", ok, out_if.out_ts, out_if.out_col);
        end
        nTOK[1] = 1'b1;
        wait_idle(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_idle busy=%b exp=0", busy); end
        @(negedge CLK);
        nTOK[1] = 1'b0; exp_ts = tb_ts;
        wait_valid(20, ok);
        checks++; if (!ok || out_if.out_ts !== exp_ts || out_if.out_ts >= 16'h0040) begin
            errors++; $display("FAIL wrap_next ok=%b ts=%h exp=%h (small)", ok, out_if.out_ts, exp_ts);
        end
        nTOK[1] = 1'b1;
        wait_idle(5, ok);
    endtask

    initial begin
        all_ones = '1;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_multi_hit();
        test_en_reset();
        test_ts_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
